// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates active-low row drive, samples synchronized
// columns once per scan tick, and debounces both press and release of one key.
module keypad_scan #(
  parameter int CLK_HZ      = 50000000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int DEB_RAW = DEBOUNCE_MS * SCAN_HZ / 1000;
  localparam int DEB     = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(DEB + 2);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic [3:0]      col_m_q;
  logic [3:0]      col_s_q;
  logic [1:0]      row_idx_q;
  logic [1:0]      row_idx_d;
  logic [3:0]      row_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      col_pat_q;
  logic [CW-1:0]   deb_cnt_q;
  logic [CW-1:0]   deb_cnt_d;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_held_q;
  logic [2:0]      col_dec;

  // {valid, column index}; only a single low column counts as a key.
  function automatic logic [2:0] decode_col(input logic [3:0] p);
    case (p)
      4'b1110: return 3'b1_00;
      4'b1101: return 3'b1_01;
      4'b1011: return 3'b1_10;
      4'b0111: return 3'b1_11;
      default: return 3'b0_00;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign tick      = (tick_cnt_q == TW'(DIV - 1));
  assign col_dec   = decode_col(col_s_q);
  assign row_idx_d = row_idx_q + 2'd1;
  assign deb_cnt_d = deb_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
    end else begin
      col_m_q <= col;
      col_s_q <= col_m_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      col_idx_q   <= 2'd0;
      col_pat_q   <= 4'hF;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (col_dec[2]) begin
              col_pat_q <= col_s_q;
              col_idx_q <= col_dec[1:0];
              deb_cnt_q <= CW'(1);
              state_q   <= DEB_PRESS;
            end else begin
              row_idx_q <= row_idx_d;
              row_q     <= row_drive(row_idx_d);
            end
          end
          DEB_PRESS: begin
            if (col_s_q == col_pat_q) begin
              if (deb_cnt_d >= CW'(DEB)) begin
                key_code_q  <= {row_idx_q, col_idx_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= PRESSED;
              end else begin
                deb_cnt_q <= deb_cnt_d;
              end
            end else begin
              state_q   <= SCAN;
              row_idx_q <= row_idx_d;
              row_q     <= row_drive(row_idx_d);
            end
          end
          PRESSED: begin
            if (col_s_q == 4'hF) begin
              deb_cnt_q <= CW'(1);
              state_q   <= DEB_RELEASE;
            end
          end
          DEB_RELEASE: begin
            // A column going low again here is a release glitch, not a new press.
            if (col_s_q == 4'hF) begin
              if (deb_cnt_d >= CW'(DEB)) begin
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                row_idx_q  <= row_idx_d;
                row_q      <= row_drive(row_idx_d);
              end else begin
                deb_cnt_q <= deb_cnt_d;
              end
            end else begin
              state_q <= PRESSED;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a behavioural keypad (pressed-key set resolved against
// the row drive) plus directed scenarios and randomized press/release timing.
module tb_keypad_scan;

  localparam int DIV = 10;
  localparam int DEB = 3;

  logic        clk;
  logic        rstn;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          cyc;
  int          valid_count;
  int          checks;
  int          failures;

  keypad_scan #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_MS(30)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .col(col),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A column reads low when any pressed key joins it to a driven (low) row.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row[r] == 1'b0 && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) valid_count <= valid_count + 1;
  end

  task automatic apply_reset(input logic [15:0] k);
    rstn = 1'b0;
    keys = k;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] er;
    keys = 16'h0;
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b expected 1110", row); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", key_held); end
    rstn = 1'b1;
    while (cyc < 50) begin
      @(negedge clk);
      er = ~(4'b0001 << ((cyc / DIV) % 4));
      checks++; if (row !== er) begin failures++; $display("FAIL idle_row cyc=%0d: got %b expected %b", cyc, row, er); end
      checks++; if (key_valid !== 1'b0 || key_code !== 4'd0) begin
        failures++; $display("FAIL idle_key cyc=%0d: got valid=%b code=%0d expected 0/0", cyc, key_valid, key_code);
      end
    end
    // Asynchronous assertion mid-cycle, well away from any clock edge.
    repeat (25) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL async_reset_row: got %b expected 1110", row); end
  endtask

  task automatic test_press_release;
    int vc0;
    logic ev;
    apply_reset(16'h0200);
    vc0 = valid_count;
    while (cyc < 60) begin
      @(negedge clk);
      ev = (cyc == (2 + DEB) * DIV);
      checks++; if (key_valid !== ev) begin failures++; $display("FAIL press_valid cyc=%0d: got %b expected %b", cyc, key_valid, ev); end
      if (cyc == (2 + DEB) * DIV) begin
        checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL press_code: got %0d expected 9", key_code); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b expected 1", key_held); end
      end
    end
    checks++; if (row !== 4'b1011) begin failures++; $display("FAIL press_row_hold: got %b expected 1011", row); end
    keys = 16'h0;
    while (cyc < 100) begin
      @(negedge clk);
      ev = (cyc < 90);
      checks++; if (key_held !== ev) begin failures++; $display("FAIL release_held cyc=%0d: got %b expected %b", cyc, key_held, ev); end
      if (cyc == 90) begin
        checks++; if (row !== 4'b0111) begin failures++; $display("FAIL release_row: got %b expected 0111", row); end
      end
    end
    checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL release_code_kept: got %0d expected 9", key_code); end
    checks++; if (valid_count - vc0 != 1) begin failures++; $display("FAIL press_pulses: got %0d expected 1", valid_count - vc0); end
  endtask

  task automatic test_bounce;
    int vc0;
    logic ev;
    apply_reset(16'h0);
    vc0 = valid_count;
    while (cyc < 90) begin
      @(negedge clk);
      if (cyc == 5)  keys = 16'h0008;
      if (cyc == 15) keys = 16'h0000;
      if (cyc == 25) keys = 16'h0008;
      ev = (cyc == 80);
      checks++; if (key_valid !== ev) begin failures++; $display("FAIL bounce_valid cyc=%0d: got %b expected %b", cyc, key_valid, ev); end
      if (cyc == 80) begin
        checks++; if (key_code !== 4'd3) begin failures++; $display("FAIL bounce_code: got %0d expected 3", key_code); end
      end
    end
    checks++; if (valid_count - vc0 != 1) begin failures++; $display("FAIL bounce_pulses: got %0d expected 1", valid_count - vc0); end
  endtask

  task automatic test_multi_key;
    logic [3:0] er;
    logic ev;
    apply_reset(16'h0030);
    while (cyc < 130) begin
      @(negedge clk);
      if (cyc == 65) keys = 16'h0010;
      if (cyc <= 90) begin
        er = ~(4'b0001 << ((cyc / DIV) % 4));
        checks++; if (row !== er) begin failures++; $display("FAIL multi_row cyc=%0d: got %b expected %b", cyc, row, er); end
      end
      ev = (cyc == 120);
      checks++; if (key_valid !== ev) begin failures++; $display("FAIL multi_valid cyc=%0d: got %b expected %b", cyc, key_valid, ev); end
      if (cyc == 120) begin
        checks++; if (key_code !== 4'd4) begin failures++; $display("FAIL multi_code: got %0d expected 4", key_code); end
      end
    end
  endtask

  task automatic test_release_glitch;
    int vc0;
    logic ev;
    apply_reset(16'h1000);
    vc0 = valid_count;
    while (cyc < 140) begin
      @(negedge clk);
      if (cyc == 61)  keys = 16'h0000;
      if (cyc == 71)  keys = 16'h1000;
      if (cyc == 101) keys = 16'h0000;
      if (cyc >= 60) begin
        ev = (cyc < 130);
        checks++; if (key_held !== ev) begin failures++; $display("FAIL glitch_held cyc=%0d: got %b expected %b", cyc, key_held, ev); end
      end
      if (cyc == 60) begin
        checks++; if (key_code !== 4'd12) begin failures++; $display("FAIL glitch_code: got %0d expected 12", key_code); end
      end
      if (cyc == 130) begin
        checks++; if (row !== 4'b1110) begin failures++; $display("FAIL glitch_row: got %b expected 1110", row); end
      end
    end
    checks++; if (valid_count - vc0 != 1) begin failures++; $display("FAIL glitch_pulses: got %0d expected 1", valid_count - vc0); end
  endtask

  task automatic test_reset_pressed;
    int vc0;
    logic ev;
    apply_reset(16'h0200);
    while (cyc < 55) @(negedge clk);
    checks++; if (key_held !== 1'b1 || key_code !== 4'd9) begin
      failures++; $display("FAIL pre_reset_state: got held=%b code=%0d expected 1/9", key_held, key_code);
    end
    #2 rstn = 1'b0;
    #1;
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL midreset_row: got %b expected 1110", row); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL midreset_code: got %0d expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midreset_held: got %b expected 0", key_held); end
    @(negedge clk);
    rstn = 1'b1;
    vc0 = valid_count;
    while (cyc < 60) begin
      @(negedge clk);
      ev = (cyc == 50);
      checks++; if (key_valid !== ev) begin failures++; $display("FAIL reaccept_valid cyc=%0d: got %b expected %b", cyc, key_valid, ev); end
      if (cyc == 49) begin
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reaccept_precode: got %0d expected 0", key_code); end
      end
      if (cyc == 50) begin
        checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL reaccept_code: got %0d expected 9", key_code); end
      end
    end
    checks++; if (valid_count - vc0 != 1) begin failures++; $display("FAIL reaccept_pulses: got %0d expected 1", valid_count - vc0); end
  endtask

  task automatic test_random;
    int k, r, t, vc0;
    logic [3:0] er;
    apply_reset(16'h0);
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 15);
      r = k / 4;
      repeat ($urandom_range(0, 37)) @(negedge clk);
      vc0 = valid_count;
      keys = 16'h0001 << k;
      t = 0;
      while (key_valid !== 1'b1 && t < (4 + DEB) * DIV + 10) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (key_valid !== 1'b1 || t < (DEB - 1) * DIV || t > (4 + DEB) * DIV + 2) begin
        failures++; $display("FAIL rand_press_latency key=%0d: got %0d clk expected %0d..%0d", k, t, (DEB - 1) * DIV, (4 + DEB) * DIV + 2);
      end
      checks++; if (key_code !== 4'(k) || key_held !== 1'b1) begin
        failures++; $display("FAIL rand_accept key=%0d: got code=%0d held=%b expected %0d/1", k, key_code, key_held, k);
      end
      er = ~(4'b0001 << r);
      repeat ($urandom_range(0, 50)) @(negedge clk);
      checks++; if (row !== er) begin failures++; $display("FAIL rand_row_hold key=%0d: got %b expected %b", k, row, er); end
      keys = 16'h0;
      t = 0;
      while (key_held !== 1'b0 && t < (DEB + 1) * DIV + 10) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (key_held !== 1'b0 || t < (DEB - 1) * DIV || t > (DEB + 1) * DIV + 2) begin
        failures++; $display("FAIL rand_release_latency key=%0d: got %0d clk expected %0d..%0d", k, t, (DEB - 1) * DIV, (DEB + 1) * DIV + 2);
      end
      er = ~(4'b0001 << ((r + 1) % 4));
      checks++; if (row !== er) begin failures++; $display("FAIL rand_row_resume key=%0d: got %b expected %b", k, row, er); end
      checks++; if (key_code !== 4'(k) || valid_count - vc0 != 1) begin
        failures++; $display("FAIL rand_single key=%0d: got code=%0d pulses=%0d expected %0d/1", k, key_code, valid_count - vc0, k);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    failures    = 0;
    valid_count = 0;
    keys        = 16'h0;
    rstn        = 1'b0;
    test_reset();
    test_press_release();
    test_bounce();
    test_multi_key();
    test_release_glitch();
    test_reset_pressed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
